// File: rtl/inst_encoder_pkg.sv
// Shared types and constants for the RV32I instruction encoder.
// The EMIT2 state exists only when INST_ENCODER_PSEUDO_LI_EN is defined.
package inst_encoder_pkg;

    typedef enum logic [3:0] {
        K_R      = 4'd0,
        K_IALU   = 4'd1,
        K_LOAD   = 4'd2,
        K_STORE  = 4'd3,
        K_BRANCH = 4'd4,
        K_JAL    = 4'd5,
        K_JALR   = 4'd6,
        K_LUI    = 4'd7,
        K_AUIPC  = 4'd8,
        K_LI     = 4'd9
    } kind_e;

    // ALU codes shared with the decoder
    typedef enum logic [4:0] {
        ALU_ADD  = 5'd0,
        ALU_SUB  = 5'd1,
        ALU_SLL  = 5'd2,
        ALU_SLT  = 5'd3,
        ALU_SLTU = 5'd4,
        ALU_XOR  = 5'd5,
        ALU_SRL  = 5'd6,
        ALU_SRA  = 5'd7,
        ALU_OR   = 5'd8,
        ALU_AND  = 5'd9,
        ALU_LUI  = 5'd10
    } alu_op_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EMIT  = 2'd1
`ifdef INST_ENCODER_PSEUDO_LI_EN
        ,
        S_EMIT2 = 2'd2
`endif
    } state_e;

    // funct3 for an ALU operation (R and I-ALU share it)
    function automatic logic [2:0] alu_funct3(input logic [4:0] op);
        case (op)
            ALU_SLL:          return 3'b001;
            ALU_SLT:          return 3'b010;
            ALU_SLTU:         return 3'b011;
            ALU_XOR:          return 3'b100;
            ALU_SRL, ALU_SRA: return 3'b101;
            ALU_OR:           return 3'b110;
            ALU_AND:          return 3'b111;
            default:          return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/inst_encoder_pack.sv
// inst_pack: combinational mapping of request kind/fields/immediate to an
// RV32I word plus an illegal flag. With INST_ENCODER_PSEUDO_LI_EN, LI may
// also produce a second (ADDI) word.
module inst_pack
    import inst_encoder_pkg::*;
(
    input  logic [3:0]  i_kind,
    input  logic [4:0]  i_alu_op,
    input  logic [2:0]  i_funct3,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    input  logic [31:0] i_imm,
    output logic [31:0] o_word,
    output logic        o_illegal
`ifdef INST_ENCODER_PSEUDO_LI_EN
    ,
    output logic [31:0] o_word2,
    output logic        o_two
`endif
);

    logic [2:0]  w_f3;
    logic        w_shift;
    logic        w_op_bad;
    logic [6:0]  w_f7;
`ifdef INST_ENCODER_PSEUDO_LI_EN
    logic        w_fits12;
    logic [19:0] w_li_hi;
    // upper part rounded so the sign-extended ADDI low part lands on imm
    assign w_li_hi  = i_imm[31:12] + {19'd0, i_imm[11]};
    assign w_fits12 = (i_imm[31:11] == '0) || (i_imm[31:11] == '1);
`endif

    assign w_f3     = alu_funct3(i_alu_op);
    assign w_shift  = (i_alu_op == ALU_SLL) || (i_alu_op == ALU_SRL) || (i_alu_op == ALU_SRA);
    // codes above LUI have no encoding at all
    assign w_op_bad = (i_alu_op > ALU_LUI);
    assign w_f7     = ((i_alu_op == ALU_SUB) || (i_alu_op == ALU_SRA)) ? 7'b0100000 : 7'b0000000;

    // per-kind encoding and legality
    always_comb begin
        o_word    = '0;
        o_illegal = 1'b0;
`ifdef INST_ENCODER_PSEUDO_LI_EN
        o_word2   = '0;
        o_two     = 1'b0;
`endif
        case (i_kind)
            K_R: begin
                o_illegal = w_op_bad || (i_alu_op == ALU_LUI);
                o_word    = {w_f7, i_rs2, i_rs1, w_f3, i_rd, OP_R};
            end
            K_IALU: begin
                o_illegal = w_op_bad || (i_alu_op == ALU_SUB) || (i_alu_op == ALU_SRA) ||
                            (i_alu_op == ALU_LUI) || (w_shift && (i_imm[31:5] != '0));
                o_word    = w_shift ? {w_f7, i_imm[4:0], i_rs1, w_f3, i_rd, OP_IALU}
                                    : {i_imm[11:0], i_rs1, w_f3, i_rd, OP_IALU};
            end
            K_LOAD: begin
                o_illegal = (i_funct3 == 3'b011) || (i_funct3 == 3'b110) || (i_funct3 == 3'b111);
                o_word    = {i_imm[11:0], i_rs1, i_funct3, i_rd, OP_LOAD};
            end
            K_STORE: begin
                o_illegal = (i_funct3 > 3'b010);
                o_word    = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], OP_STORE};
            end
            K_BRANCH: begin
                o_illegal = (i_funct3 == 3'b010) || (i_funct3 == 3'b011);
                o_word    = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                             i_imm[4:1], i_imm[11], OP_BRANCH};
            end
            K_JAL:   o_word = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, OP_JAL};
            K_JALR:  o_word = {i_imm[11:0], i_rs1, 3'b000, i_rd, OP_JALR};
            K_LUI:   o_word = {i_imm[31:12], i_rd, OP_LUI};
            K_AUIPC: o_word = {i_imm[31:12], i_rd, OP_AUIPC};
`ifdef INST_ENCODER_PSEUDO_LI_EN
            K_LI: begin
                if (w_fits12) begin
                    o_word = {i_imm[11:0], 5'd0, 3'b000, i_rd, OP_IALU};
                end else if (i_imm[11:0] == '0) begin
                    o_word = {i_imm[31:12], i_rd, OP_LUI};
                end else begin
                    o_word  = {w_li_hi, i_rd, OP_LUI};
                    o_word2 = {i_imm[11:0], i_rd, 3'b000, i_rd, OP_IALU};
                    o_two   = 1'b1;
                end
            end
`endif
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/inst_encoder.sv
// inst_encoder: accepts encode requests, writes RV32I words to instruction
// memory at consecutive addresses from BASE_ADDR. Optional LI pseudo-op
// expansion (two-word LUI+ADDI) is enabled by INST_ENCODER_PSEUDO_LI_EN.
module inst_encoder
    import inst_encoder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_kind,
    input  logic [4:0]  alu_op,
    input  logic [2:0]  funct3_in,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic        wr_en,
    input  logic        wr_ready,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        err,
    output logic [15:0] words
);

    state_e      r_state;
    logic [31:0] r_data;
    logic [31:0] r_addr;
    logic [15:0] r_words;
    logic        r_err;

    logic [31:0] w_word;
    logic        w_illegal;
    logic        w_hs;
    logic        w_acc;
    logic        w_req_ready;
    logic        w_two_pend;

`ifdef INST_ENCODER_PSEUDO_LI_EN
    logic [31:0] w_word2;
    logic        w_two;
    logic [31:0] r_word2;
    logic        r_two;
    assign w_two_pend = r_two;
`else
    assign w_two_pend = 1'b0;
`endif

    inst_pack u_pack (
        .i_kind    (req_kind),
        .i_alu_op  (alu_op),
        .i_funct3  (funct3_in),
        .i_rd      (rd),
        .i_rs1     (rs1),
        .i_rs2     (rs2),
        .i_imm     (imm),
        .o_word    (w_word),
        .o_illegal (w_illegal)
`ifdef INST_ENCODER_PSEUDO_LI_EN
        ,
        .o_word2   (w_word2),
        .o_two     (w_two)
`endif
    );

    // ready in IDLE, or in EMIT when the current word leaves this cycle and nothing follows it
    always_comb begin
        w_req_ready = 1'b0;
        if (rst) begin
            case (r_state)
                S_IDLE:  w_req_ready = 1'b1;
                S_EMIT:  w_req_ready = wr_ready & ~w_two_pend;
                default: w_req_ready = 1'b0;
            endcase
        end
    end

    assign wr_en     = (r_state != S_IDLE);
    assign w_hs      = wr_en & wr_ready;
    assign w_acc     = req_valid & w_req_ready;
    assign req_ready = w_req_ready;
    assign wr_addr   = r_addr;
    assign wr_data   = r_data;
    assign err       = r_err;
    assign words     = r_words;

    // FSM, output word register, address and word counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_data  <= '0;
            r_addr  <= BASE_ADDR;
            r_words <= '0;
            r_err   <= 1'b0;
`ifdef INST_ENCODER_PSEUDO_LI_EN
            r_word2 <= '0;
            r_two   <= 1'b0;
`endif
        end else begin
            if (w_hs) begin
                r_addr <= r_addr + 32'd4;
                if (r_words != 16'hFFFF) r_words <= r_words + 16'd1;
            end
            if (w_acc && w_illegal) r_err <= 1'b1;

            if (w_acc && !w_illegal) begin
                r_data  <= w_word;
`ifdef INST_ENCODER_PSEUDO_LI_EN
                r_word2 <= w_word2;
                r_two   <= w_two;
`endif
                r_state <= S_EMIT;
            end
`ifdef INST_ENCODER_PSEUDO_LI_EN
            else if (w_hs && r_two) begin
                r_data  <= r_word2;
                r_two   <= 1'b0;
                r_state <= S_EMIT2;
            end
`endif
            else if (w_hs) begin
                r_state <= S_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_inst_encoder.sv
// Directed self-checking bench for inst_encoder. Works with and without
// INST_ENCODER_PSEUDO_LI_EN. A second instance with BASE_ADDR=FFFF_FFFC
// shares the stimulus to check address wrap.
module tb_inst_encoder;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, req_valid, wr_ready;
    logic [3:0]  req_kind;
    logic [4:0]  alu_op, rd, rs1, rs2;
    logic [2:0]  funct3_in;
    logic [31:0] imm;

    logic        req_ready, wr_en, err;
    logic [31:0] wr_addr, wr_data;
    logic [15:0] words;

    logic        z_req_ready, z_wr_en, z_err;
    logic [31:0] z_wr_addr, z_wr_data;
    logic [15:0] z_words;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_addr;
    logic [15:0] exp_words;

    inst_encoder #(.BASE_ADDR(32'h0000_0100)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_kind(req_kind), .alu_op(alu_op), .funct3_in(funct3_in),
        .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
        .wr_en(wr_en), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .err(err), .words(words)
    );

    inst_encoder #(.BASE_ADDR(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(z_req_ready),
        .req_kind(req_kind), .alu_op(alu_op), .funct3_in(funct3_in),
        .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
        .wr_en(z_wr_en), .wr_ready(wr_ready), .wr_addr(z_wr_addr), .wr_data(z_wr_data),
        .err(z_err), .words(z_words)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [3:0] k, input logic [4:0] op, input logic [2:0] f3,
                       input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                       input logic [31:0] im);
        req_valid = 1'b1; req_kind = k; alu_op = op; funct3_in = f3;
        rd = d; rs1 = s1; rs2 = s2; imm = im;
    endtask

    // one request from IDLE with wr_ready=1: single word, then back to idle
    task automatic send1(input string tag, input logic [3:0] k, input logic [4:0] op,
                         input logic [2:0] f3, input logic [4:0] d, input logic [4:0] s1,
                         input logic [4:0] s2, input logic [31:0] im, input logic [31:0] expw);
        req(k, op, f3, d, s1, s2, im);
        tick;
        req_valid = 1'b0;
        chk({tag, ".data"}, wr_data, expw);
        chk({tag, ".addr"}, wr_addr, exp_addr);
        tick;
        exp_addr  = exp_addr + 32'd4;
        exp_words = exp_words + 16'd1;
        chk({tag, ".words"}, {16'd0, words}, {16'd0, exp_words});
        chk({tag, ".idle"}, {31'd0, wr_en}, 32'd0);
    endtask

    initial begin
        rst = 1'b0; req_valid = 1'b0; wr_ready = 1'b0;
        req_kind = '0; alu_op = '0; funct3_in = '0; rd = '0; rs1 = '0; rs2 = '0; imm = '0;
        tick; tick;

        // reset state
        chk("rst.ready", {31'd0, req_ready}, 32'd0);
        chk("rst.wr_en", {31'd0, wr_en}, 32'd0);
        chk("rst.data",  wr_data, 32'd0);
        chk("rst.err",   {31'd0, err}, 32'd0);
        chk("rst.words", {16'd0, words}, 32'd0);
        chk("rst.addr",  wr_addr, 32'h0000_0100);
        chk("rst.waddr", z_wr_addr, 32'hFFFF_FFFC);

        rst = 1'b1;
        #1;
        chk("post_rst.ready", {31'd0, req_ready}, 32'd1);

        // back-to-back: ADD, ADDI, SW, BEQ
        wr_ready = 1'b1;
        req(4'd0, 5'd0, 3'd0, 5'd3, 5'd1, 5'd2, 32'd0);
        tick;
        chk("add.wr_en", {31'd0, wr_en}, 32'd1);
        chk("add.data",  wr_data, 32'h002081B3);
        chk("add.addr",  wr_addr, 32'h0000_0100);
        chk("wrap.addr0", z_wr_addr, 32'hFFFF_FFFC);
        req(4'd1, 5'd0, 3'd0, 5'd5, 5'd0, 5'd0, 32'hFFFF_FFFF);
        #1;
        chk("add.ready", {31'd0, req_ready}, 32'd1);
        tick;
        chk("addi.wr_en", {31'd0, wr_en}, 32'd1);
        chk("addi.data",  wr_data, 32'hFFF00293);
        chk("addi.addr",  wr_addr, 32'h0000_0104);
        chk("addi.words", {16'd0, words}, 32'd1);
        chk("wrap.addr1", z_wr_addr, 32'h0000_0000);
        req(4'd3, 5'd0, 3'b010, 5'd0, 5'd1, 5'd2, 32'd8);
        tick;
        chk("sw.data", wr_data, 32'h0020A423);
        chk("sw.addr", wr_addr, 32'h0000_0108);
        req(4'd4, 5'd0, 3'b000, 5'd0, 5'd1, 5'd2, 32'd8);
        tick;
        chk("beq.data",  wr_data, 32'h00208463);
        chk("beq.addr",  wr_addr, 32'h0000_010C);
        chk("beq.words", {16'd0, words}, 32'd3);

        // backpressure with a LUI waiting
        wr_ready = 1'b0;
        req(4'd7, 5'd0, 3'd0, 5'd7, 5'd0, 5'd0, 32'hABCD_E000);
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("bp.ready", {31'd0, req_ready}, 32'd0);
            chk("bp.wr_en", {31'd0, wr_en}, 32'd1);
            chk("bp.data",  wr_data, 32'h00208463);
            chk("bp.addr",  wr_addr, 32'h0000_010C);
            chk("bp.words", {16'd0, words}, 32'd3);
            tick;
        end
        wr_ready = 1'b1;
        #1;
        chk("bp.release_ready", {31'd0, req_ready}, 32'd1);
        tick;
        req_valid = 1'b0;
        chk("lui.data",  wr_data, 32'hABCDE3B7);
        chk("lui.addr",  wr_addr, 32'h0000_0110);
        chk("lui.words", {16'd0, words}, 32'd4);
        tick;
        chk("lui.done_en", {31'd0, wr_en}, 32'd0);
        chk("lui.words2",  {16'd0, words}, 32'd5);
        tick;
        chk("lui.once",    {16'd0, words}, 32'd5);
        chk("lui.addr2",   wr_addr, 32'h0000_0114);
        exp_addr  = 32'h0000_0114;
        exp_words = 16'd5;

        // more formats
        send1("sra",   4'd0, 5'd7, 3'd0,   5'd4,  5'd5, 5'd6, 32'd0,         32'h4062D233);
        send1("slli",  4'd1, 5'd2, 3'd0,   5'd1,  5'd2, 5'd0, 32'd3,         32'h00311093);
        send1("jal",   4'd5, 5'd0, 3'd0,   5'd1,  5'd0, 5'd0, 32'h0000_0800, 32'h001000EF);
        send1("auipc", 4'd8, 5'd0, 3'd0,   5'd10, 5'd0, 5'd0, 32'h0000_1000, 32'h00001517);
        send1("lw",    4'd2, 5'd0, 3'b010, 5'd6,  5'd8, 5'd0, 32'hFFFF_FFFC, 32'hFFC42303);

`ifdef INST_ENCODER_PSEUDO_LI_EN
        // LI needing LUI+ADDI; a waiting request must not be taken in between
        req(4'd9, 5'd0, 3'd0, 5'd1, 5'd0, 5'd0, 32'h1234_5FFF);
        tick;
        req(4'd0, 5'd0, 3'd0, 5'd3, 5'd1, 5'd2, 32'd0);
        #1;
        chk("li.w1", wr_data, 32'h123460B7);
        chk("li.ready1", {31'd0, req_ready}, 32'd0);
        tick;
        chk("li.w2", wr_data, 32'hFFF08093);
        chk("li.addr2", wr_addr, exp_addr + 32'd4);
        chk("li.ready2", {31'd0, req_ready}, 32'd0);
        chk("li.wr_en2", {31'd0, wr_en}, 32'd1);
        req_valid = 1'b0;
        tick;
        exp_addr  = exp_addr + 32'd8;
        exp_words = exp_words + 16'd2;
        chk("li.idle",  {31'd0, wr_en}, 32'd0);
        chk("li.words", {16'd0, words}, {16'd0, exp_words});
        chk("li.err",   {31'd0, err}, 32'd0);
        send1("li.small", 4'd9, 5'd0, 3'd0, 5'd2, 5'd0, 5'd0, 32'd5,         32'h00500113);
        send1("li.upper", 4'd9, 5'd0, 3'd0, 5'd3, 5'd0, 5'd0, 32'h1234_5000, 32'h123451B7);
`else
        req(4'd9, 5'd0, 3'd0, 5'd1, 5'd0, 5'd0, 32'h1234_5FFF);
        tick;
        req_valid = 1'b0;
        chk("li_off.err",   {31'd0, err}, 32'd1);
        chk("li_off.wr_en", {31'd0, wr_en}, 32'd0);
        tick;
        chk("li_off.words", {16'd0, words}, {16'd0, exp_words});
`endif

        // illegal requests: nothing written
        req(4'd1, 5'd1, 3'd0, 5'd1, 5'd1, 5'd0, 32'd1);
        tick;
        req_valid = 1'b0;
        #1;
        chk("ill_sub.err",   {31'd0, err}, 32'd1);
        chk("ill_sub.wr_en", {31'd0, wr_en}, 32'd0);
        chk("ill_sub.ready", {31'd0, req_ready}, 32'd1);
        req(4'd12, 5'd0, 3'd0, 5'd1, 5'd1, 5'd0, 32'd0);
        tick;
        chk("ill_kind.wr_en", {31'd0, wr_en}, 32'd0);
        req(4'd1, 5'd2, 3'd0, 5'd1, 5'd1, 5'd0, 32'd32);
        tick;
        chk("ill_shamt.wr_en", {31'd0, wr_en}, 32'd0);
        req(4'd4, 5'd0, 3'b010, 5'd0, 5'd1, 5'd2, 32'd8);
        tick;
        chk("ill_br.wr_en", {31'd0, wr_en}, 32'd0);
        req(4'd0, 5'd10, 3'd0, 5'd1, 5'd1, 5'd2, 32'd0);
        tick;
        req_valid = 1'b0;
        chk("ill_rlui.wr_en", {31'd0, wr_en}, 32'd0);
        chk("ill.words", {16'd0, words}, {16'd0, exp_words});
        chk("ill.addr",  wr_addr, exp_addr);

        // asynchronous reset mid-transfer
        wr_ready = 1'b0;
`ifdef INST_ENCODER_PSEUDO_LI_EN
        req(4'd9, 5'd0, 3'd0, 5'd1, 5'd0, 5'd0, 32'h1234_5FFF);
        tick;
        req_valid = 1'b0;
        wr_ready  = 1'b1;
        tick;
        wr_ready  = 1'b0;
        #1;
        chk("e2.data", wr_data, 32'hFFF08093);
`else
        req(4'd0, 5'd0, 3'd0, 5'd3, 5'd1, 5'd2, 32'd0);
        tick;
        req_valid = 1'b0;
        #1;
        chk("e1.data", wr_data, 32'h002081B3);
`endif
        chk("mid.wr_en", {31'd0, wr_en}, 32'd1);
        #1;
        rst = 1'b0;
        #1;
        chk("arst.wr_en", {31'd0, wr_en}, 32'd0);
        chk("arst.addr",  wr_addr, 32'h0000_0100);
        chk("arst.err",   {31'd0, err}, 32'd0);
        chk("arst.words", {16'd0, words}, 32'd0);
        chk("arst.data",  wr_data, 32'd0);
        chk("arst.ready", {31'd0, req_ready}, 32'd0);
        tick;
        rst = 1'b1;
        #1;
        chk("rel.ready", {31'd0, req_ready}, 32'd1);
        chk("rel.wr_en", {31'd0, wr_en}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/inst_encoder.md
INST_ENCODER -- requirements
Module: inst_encoder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000, meaning the first instruction-memory byte address written after reset.
REQ-002 SHALL have ports:
  - clk  input  1: sole clock.
  - rst  input  1: asynchronous, active-low reset.
  - req_valid  input  1: encode request present.
  - req_ready  output  1: request accepted this cycle when high with req_valid.
  - req_kind  input  4: 0 R, 1 I-ALU, 2 LOAD, 3 STORE, 4 BRANCH, 5 JAL, 6 JALR, 7 LUI, 8 AUIPC, 9 LI; others illegal.
  - alu_op  input  5: ALU code, shared encoding ADD=0 through LUI=10; used for R and I-ALU.
  - funct3_in  input  3: width or condition for LOAD, STORE and BRANCH.
  - rd, rs1, rs2  input  5 each: register indices.
  - imm  input  32: signed immediate or offset; LUI/AUIPC take imm[31:12].
  - wr_en  output  1: instruction word valid toward instruction memory.
  - wr_ready  input  1: memory accepts the word this cycle.
  - wr_addr  output  32: byte address of wr_data.
  - wr_data  output  32: encoded RV32I word.
  - err  output  1: sticky flag, set by an illegal request.
  - words  output  16: count of words written, saturating.

Function
REQ-003 SHALL run an FSM with states IDLE, EMIT and EMIT2.
REQ-004 SHALL drive req_ready=1 in IDLE, and in EMIT when wr_ready=1 and no second word is pending; req_ready=0 otherwise.
REQ-005 SHALL register a legal accepted request's word, so wr_en=1 in the next cycle (latency 1) and the FSM enters EMIT.
REQ-006 SHALL hold wr_data and wr_addr stable while wr_en=1 and wr_ready=0.
REQ-007 SHALL, on each wr_en&wr_ready handshake:
  - add 4 to wr_addr, wrapping 32'hFFFF_FFFC to 0;
  - increment words, saturating at 16'hFFFF.
REQ-008 SHALL support back-to-back operation: a request accepted on the final handshake cycle gives wr_en=1 again next cycle with no bubble.
REQ-009 SHALL encode each kind as:
  - R: opcode 0110011; funct7=0100000 for SUB and SRA, else 0.
  - I-ALU: opcode 0010011; shifts put imm[4:0] in the shamt field and funct7 in [31:25].
  - LOAD: opcode 0000011.
  - STORE: opcode 0100011, S-format immediate.
  - BRANCH: opcode 1100011, B-format immediate, imm[0] ignored.
  - JAL: opcode 1101111, J-format immediate.
  - JALR: opcode 1100111, funct3 000.
  - LUI: opcode 0110111.
  - AUIPC: opcode 0010111.
REQ-010 SHALL treat these requests as illegal:
  - req_kind greater than 9.
  - SUB, SRA or LUI as alu_op for I-ALU.
  - LUI as alu_op for R.
  - imm[31:5] nonzero for a shift.
  - LOAD funct3 of 011, 110 or 111.
  - STORE funct3 greater than 010.
  - BRANCH funct3 of 010 or 011.
REQ-011 SHALL handle an illegal request as follows: accept it, write nothing, set err, and stay in IDLE.
REQ-012 SHALL encode LI (kind 9) as follows:
  - If imm fits a signed 12-bit value: one ADDI rd,x0,imm.
  - Else if imm[11:0]==0: one LUI rd,imm[31:12].
  - Else: LUI rd,(imm+32'h800)[31:12] in EMIT, then ADDI rd,rd,imm[11:0] in EMIT2.
REQ-013 SHALL keep req_ready=0 until the EMIT2 handshake completes.

Reset
REQ-014 SHALL, when rst=0 and regardless of clk:
  - force IDLE, req_ready=0, wr_en=0, wr_data=0, err=0, words=0, wr_addr=BASE_ADDR;
  - discard any pending word or second LI word.
REQ-015 SHALL assert req_ready in the first cycle after rst returns to 1.

Configuration
REQ-016 SHALL implement LI expansion only when macro INST_ENCODER_PSEUDO_LI_EN is defined; without it, kind 9 is illegal per REQ-011, EMIT2 is absent, and all other behaviour is identical.

Structure
REQ-017 SHALL place in a shared package the req_kind enum, the ALU op codes (shared with the decoder), the opcode constants and the FSM state type.
REQ-018 SHALL use one combinational sub-module, inst_pack, which maps the kind, fields and immediate to a 32-bit word plus an illegal flag; the FSM, counters and handshake stay in inst_encoder.

Verification
REQ-019 R-type: ADD x3,x1,x2 with wr_ready=1 -> wr_en next cycle, wr_data=32'h002081B3, wr_addr=BASE_ADDR.
REQ-020 Immediate forms, back-to-back:
  - ADDI x5,x0,-1 -> 32'hFFF00293.
  - SW x2,8(x1) -> 32'h0020A423.
  - BEQ x1,x2,+8 -> 32'h00208463.
  - Addresses increment by 4, no bubbles.
REQ-021 LI x1,32'h12345FFF (macro defined) -> 32'h123460B7 then 32'hFFF08093; req_ready low until the second handshake; without the macro -> err=1, no write.
REQ-022 Backpressure: wr_ready=0 for 5 cycles -> wr_data and wr_addr stable, req_ready=0, words unchanged; release -> exactly one write.
REQ-023 Illegal and reset cases:
  - I-ALU with alu_op=SUB -> err=1, no wr_en.
  - Reset in EMIT2 -> wr_en=0 immediately, wr_addr=BASE_ADDR, err=0.
REQ-024 Wrap: BASE_ADDR=32'hFFFF_FFFC, two writes -> wr_addr FFFF_FFFC then 0000_0000.
